// File: rtl/pwm_fade_sched.sv
// Shared duty-cycle ramp scheduler for an NCH-channel PWM bank.
// One time-shared engine walks all channels per fade tick; DUTY applies only at each channel's period end.
module pwm_fade_sched #(
    parameter int NCH    = 8,
    parameter int W      = 28,
    parameter int CW     = 3,
    parameter int TICK_W = 24
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CFG_WE,
    input  logic [CW-1:0]     CFG_CH,
    input  logic [W-1:0]      CFG_TARGET,
    input  logic [W-1:0]      CFG_STEP,
    input  logic [TICK_W-1:0] TICK_DIV,
    input  logic [NCH-1:0]    PER_END,
    output logic [NCH*W-1:0]  DUTY,
    output logic [NCH-1:0]    ACTIVE,
    output logic [NCH-1:0]    DONE,
    output logic              OVERRUN
);

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     ch, ch_nxt;
    logic              tick_pend, pend_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic [W-1:0]      shadow [NCH];
    logic [W-1:0]      target [NCH];
    logic [W-1:0]      step   [NCH];
    logic [W-1:0]      shadow_nxt [NCH];
    logic [NCH-1:0]    active_nxt, done_nxt;
    logic              overrun_nxt;

    logic              visit;
    logic [W-1:0]      cur, tgt, stp, diff, move, eng_res;

    assign tick = (tick_cnt == TICK_DIV);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Clamped step toward target; never crosses or wraps.
    always_comb begin
        cur   = shadow[ch];
        tgt   = target[ch];
        stp   = step[ch];
        visit = (state == SCAN) && ACTIVE[ch];
        if (cur < tgt) diff = tgt - cur;
        else           diff = cur - tgt;
        move    = (stp < diff) ? stp : diff;
        eng_res = (cur < tgt) ? cur + move : cur - move;
    end

    always_comb begin
        shadow_nxt = shadow;
        active_nxt = ACTIVE;
        done_nxt   = '0;
        if (visit) begin
            shadow_nxt[ch] = eng_res;
            if (eng_res == tgt) begin
                active_nxt[ch] = 1'b0;
                done_nxt[ch]   = 1'b1;
            end
        end
        // A config write overrides any engine result for the same channel.
        if (CFG_WE) begin
            if ((CFG_STEP == '0) || (CFG_TARGET == shadow[CFG_CH])) begin
                shadow_nxt[CFG_CH] = CFG_TARGET;
                active_nxt[CFG_CH] = 1'b0;
                done_nxt[CFG_CH]   = 1'b1;
            end else begin
                shadow_nxt[CFG_CH] = shadow[CFG_CH];
                active_nxt[CFG_CH] = 1'b1;
                done_nxt[CFG_CH]   = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        pend_nxt    = tick_pend;
        overrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if ((tick || tick_pend) && (|ACTIVE)) begin
                    state_nxt = SCAN;
                    ch_nxt    = '0;
                    pend_nxt  = 1'b0;
                end
            end
            SCAN: begin
                ch_nxt = ch + 1'b1;
                if (tick) begin
                    if (tick_pend) overrun_nxt = 1'b1;
                    else           pend_nxt    = 1'b1;
                end
                // A pending tick restarts directly from the last slot so scans run back to back.
                if (ch == CW'(NCH - 1)) begin
                    if ((tick || tick_pend) && (|active_nxt)) begin
                        state_nxt = SCAN;
                        ch_nxt    = '0;
                        pend_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            ch        <= '0;
            tick_pend <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            tick_pend <= pend_nxt;
            OVERRUN   <= overrun_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                target[i] <= '0;
                step[i]   <= '0;
            end
            ACTIVE <= '0;
            DONE   <= '0;
            DUTY   <= '0;
        end else begin
            shadow <= shadow_nxt;
            ACTIVE <= active_nxt;
            DONE   <= done_nxt;
            if (CFG_WE) begin
                target[CFG_CH] <= CFG_TARGET;
                step[CFG_CH]   <= CFG_STEP;
            end
            for (int unsigned c = 0; c < NCH; c++) begin
                if (PER_END[c]) DUTY[c*W +: W] <= shadow[c];
            end
        end
    end

endmodule
